// File: rtl/conv_weight_loader.sv
// Streams one conv layer's parameter set (kernel, biases, MACC coeff, scale) from a
// valid/ready source into the conv weight write port, then enables the layer datapath.
module conv_weight_loader #(
  parameter int          KERNEL_0         = 3,
  parameter int          KERNEL_1         = 3,
  parameter int          IN_CHANNEL       = 2,
  parameter int          OUT_CHANNEL      = 4,
  parameter int unsigned KERNEL_BASE_ADDR = 0,
  localparam int NUM_KERNEL  = KERNEL_0 * KERNEL_1 * IN_CHANNEL * OUT_CHANNEL,
  localparam int TOTAL_WORDS = NUM_KERNEL + OUT_CHANNEL + 2,
  localparam int CNT_W       = $clog2(TOTAL_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      weight_wr_data,
  output logic [31:0]      weight_wr_addr,
  output logic             weight_wr_en,
  output logic             busy,
  output logic             done,
  output logic             layer_en,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   load_start;
  logic   last_word;

  // abort masks the accept so a word offered in the abort cycle is never written
  assign accept     = s_ready && s_valid && !abort;
  assign load_start = start && !abort && (state == IDLE || state == DONE);
  assign last_word  = (word_cnt == CNT_W'(TOTAL_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nxt = LOAD;
        LOAD:    if (accept && last_word) state_nxt = DRAIN;
        DRAIN:   state_nxt = DONE;
        DONE:    if (start) state_nxt = LOAD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready  = (state == LOAD);
    busy     = (state == LOAD) || (state == DRAIN);
    done     = (state == DONE);
    layer_en = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst)             word_cnt <= '0;
    else if (load_start) word_cnt <= '0;
    else if (accept)     word_cnt <= word_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_wr_en   <= 1'b0;
      weight_wr_data <= '0;
      weight_wr_addr <= '0;
    end else begin
      weight_wr_en <= accept;
      if (accept) begin
        weight_wr_data <= s_data;
        weight_wr_addr <= KERNEL_BASE_ADDR + 32'(word_cnt);
      end
    end
  end

endmodule
